// File: rtl/hir_share_pkg.sv
// hir_share_pkg: shared types and helpers for shared-resource controllers
package hir_share_pkg;
    typedef logic [31:0] stat_t;
    localparam stat_t STAT_MAX = 32'hFFFF_FFFF;
    function automatic int tag_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mul_share_arbiter_if.sv
// mul_share_arbiter_if: requester-side bus of the shared multiplier
interface mul_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_grant;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [WIDTH-1:0]         resp_data;
    logic                     busy;
    modport master(output req_valid, req_a, req_b, input req_grant, resp_valid, resp_data, busy);
    modport slave(input req_valid, req_a, req_b, output req_grant, resp_valid, resp_data, busy);
endinterface

// File: rtl/mul_share_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request at or above ptr (wrapping)
module rr_arbiter
    import hir_share_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = tag_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    logic [N-1:0] one;
    assign one = {{(N-1){1'b0}}, 1'b1};
    // Walk from farthest to nearest so the closest request to ptr wins.
    always_comb begin
        gnt = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (|(req & (one << ((32'(ptr) + k) % N)))) gnt = one << ((32'(ptr) + k) % N);
        end
    end
endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: one pipelined multiplier shared by NUM_REQ requesters, round-robin issue.
// Optional MUL_SHARE_ARBITER_STATS_EN adds saturating grant/stall counters.
module mul_share_arbiter
    import hir_share_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 3
) (
    input  logic clk,
    input  logic rst,
    mul_share_arbiter_if.slave bus
`ifdef MUL_SHARE_ARBITER_STATS_EN
    ,
    output stat_t stat_issued,
    output stat_t stat_stalls
`endif
);
    localparam int PTR_W = tag_w(NUM_REQ);
    logic [PTR_W-1:0]       ptr, ptr_nxt;
    logic [NUM_REQ-1:0]     gnt, issue;
    logic [WIDTH-1:0]       a_sel, b_sel, prod;
    logic [MUL_LATENCY-1:0] stg_v;
    logic [NUM_REQ-1:0]     stg_tag [MUL_LATENCY];
    logic [WIDTH-1:0]       stg_p   [MUL_LATENCY];

    rr_arbiter #(.N(NUM_REQ), .PW(PTR_W)) u_arb (.req(bus.req_valid), .ptr(ptr), .gnt(gnt));

    assign issue = rst ? '0 : gnt;
    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        ptr_nxt = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (issue[i]) begin
                a_sel   = bus.req_a[i*WIDTH +: WIDTH];
                b_sel   = bus.req_b[i*WIDTH +: WIDTH];
                ptr_nxt = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end
    assign prod = a_sel * b_sel;

    // Tag and valid shift with the product so bubbles and owners stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            stg_v <= '0;
            for (int k = 0; k < MUL_LATENCY; k++) begin
                stg_tag[k] <= '0;
                stg_p[k]   <= '0;
            end
        end else begin
            ptr        <= ptr_nxt;
            stg_v[0]   <= |issue;
            stg_tag[0] <= issue;
            stg_p[0]   <= prod;
            for (int k = 1; k < MUL_LATENCY; k++) begin
                stg_v[k]   <= stg_v[k-1];
                stg_tag[k] <= stg_tag[k-1];
                stg_p[k]   <= stg_p[k-1];
            end
        end
    end

    assign bus.req_grant  = issue;
    assign bus.resp_valid = stg_v[MUL_LATENCY-1] ? stg_tag[MUL_LATENCY-1] : '0;
    assign bus.resp_data  = stg_v[MUL_LATENCY-1] ? stg_p[MUL_LATENCY-1] : '0;
    assign bus.busy       = |stg_v;

`ifdef MUL_SHARE_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued <= '0;
            stat_stalls <= '0;
        end else begin
            if (|issue && stat_issued != STAT_MAX) stat_issued <= stat_issued + 1'b1;
            if (|(bus.req_valid & ~issue) && stat_stalls != STAT_MAX) stat_stalls <= stat_stalls + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: scoreboard bench for the shared multiplier arbiter
module tb_mul_share_arbiter;
    import hir_share_pkg::*;
    localparam int N = 4;
    localparam int W = 32;
    localparam int L = 3;

    typedef struct {
        logic [N-1:0] tag;
        logic [W-1:0] data;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_share_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();
`ifdef MUL_SHARE_ARBITER_STATS_EN
    stat_t si, ss;
`endif
    mul_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .MUL_LATENCY(L)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef MUL_SHARE_ARBITER_STATS_EN
        ,
        .stat_issued(si),
        .stat_stalls(ss)
`endif
    );

    exp_t         q[$];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           mptr = 0;
    bit           mon_en = 0;
    logic [W-1:0] opa [N];
    logic [W-1:0] opb [N];

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: every cycle must match the scoreboard head or be idle with zero data.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (q.size() > 0 && q[0].due == cyc) begin
                if (bus.resp_valid !== q[0].tag || bus.resp_data !== q[0].data) begin
                    errors++;
                    $display("FAIL resp cyc=%0d: got valid=%b data=%h, want valid=%b data=%h",
                             cyc, bus.resp_valid, bus.resp_data, q[0].tag, q[0].data);
                end
                void'(q.pop_front());
            end else if (bus.resp_valid !== '0 || bus.resp_data !== '0) begin
                errors++;
                $display("FAIL idle cyc=%0d: got valid=%b data=%h, want valid=0 data=0",
                         cyc, bus.resp_valid, bus.resp_data);
            end
        end
    end

    task automatic step(input logic [N-1:0] v, output logic [N-1:0] g, output logic [N-1:0] act);
        bus.req_valid = v;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*W +: W] = opa[i];
            bus.req_b[i*W +: W] = opb[i];
        end
        g = '0;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                int idx = (mptr + k) % N;
                if (v[idx] && g == '0) g[idx] = 1'b1;
            end
            for (int i = 0; i < N; i++) if (g[i]) mptr = (i + 1) % N;
        end
        @(negedge clk);
        act = bus.req_grant;
        checks++;
        if (act !== g) begin
            errors++;
            $display("FAIL grant cyc=%0d: got %b, want %b", cyc, act, g);
        end
        for (int i = 0; i < N; i++) if (g[i]) q.push_back('{g, opa[i] * opb[i], cyc + L});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic [N-1:0] g, act;
        repeat (n) step('0, g, act);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '1;
        bus.req_a = '0;
        bus.req_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.req_grant !== '0 || bus.resp_valid !== '0 || bus.resp_data !== '0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: got grant=%b valid=%b data=%h busy=%b, want all zero",
                     bus.req_grant, bus.resp_valid, bus.resp_data, bus.busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid = '0;
        mptr = 0;
        mon_en = 1;
    endtask

    task automatic test_all();
        logic [N-1:0] pending, g, act;
        pending = '1;
        for (int i = 0; i < N; i++) begin
            opa[i] = $urandom;
            opb[i] = $urandom;
        end
        for (int j = 0; j < N; j++) begin
            step(pending, g, act);
            checks++;
            if (act !== (N'(1) << j)) begin
                errors++;
                $display("FAIL all_order j=%0d: got %b, want %b", j, act, N'(1) << j);
            end
            pending &= ~g;
        end
        idle(L + 1);
    endtask

    task automatic test_single();
        logic [N-1:0] g, act;
        opa[2] = 32'd7;
        opb[2] = 32'd6;
        step(4'b0100, g, act);
        checks++;
        if (act !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant: got %b, want 0100", act);
        end
        idle(L - 1);
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 4'b0100 || bus.resp_data !== 32'd42 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_resp: got valid=%b data=%0d busy=%b, want 0100 42 1",
                     bus.resp_valid, bus.resp_data, bus.busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        logic [N-1:0] pending, g, act;
        pending = 4'b1001;
        step(pending, g, act);
        checks++;
        if (act !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_first: got %b, want 1000", act);
        end
        pending &= ~g;
        step(pending, g, act);
        checks++;
        if (act !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_second: got %b, want 0001", act);
        end
        step(4'b0010, g, act);
        checks++;
        if (act !== 4'b0010) begin
            errors++;
            $display("FAIL wrap_third: got %b, want 0010", act);
        end
        idle(L + 1);
    endtask

    task automatic test_arith();
        logic [N-1:0] g, act;
        opa[0] = 32'hFFFF_FFFF;
        opb[0] = 32'd2;
        opa[1] = 32'h0001_0000;
        opb[1] = 32'h0001_0000;
        step(4'b0001, g, act);
        step(4'b0010, g, act);
        idle(L - 2);
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 4'b0001 || bus.resp_data !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL arith_max: got valid=%b data=%h, want 0001 fffffffe", bus.resp_valid, bus.resp_data);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 4'b0010 || bus.resp_data !== 32'h0) begin
            errors++;
            $display("FAIL arith_trunc: got valid=%b data=%h, want 0010 00000000", bus.resp_valid, bus.resp_data);
        end
        @(posedge clk);
        #1;
        idle(2);
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] g, act;
        opa[0] = 32'd3;
        opb[0] = 32'd5;
        opa[1] = 32'd9;
        opb[1] = 32'd11;
        step(4'b0001, g, act);
        step(4'b0010, g, act);
        rst = 1'b1;
        q.delete();
        mptr = 0;
        step('0, g, act);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_busy: got %b, want 0", bus.busy);
        end
        @(posedge clk);
        #1;
        idle(L + 2);
        step(4'b1110, g, act);
        checks++;
        if (act !== 4'b0010) begin
            errors++;
            $display("FAIL reset_mid_ptr: got %b, want 0010", act);
        end
        idle(L + 1);
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] g, act;
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < N; i++) begin
                opa[i] = $urandom;
                opb[i] = $urandom;
            end
            step(N'($urandom_range(0, 15)), g, act);
        end
        idle(L + 2);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
    endtask

`ifdef MUL_SHARE_ARBITER_STATS_EN
    task automatic test_stats();
        logic [N-1:0] pending, g, act;
        rst = 1'b1;
        q.delete();
        mptr = 0;
        step('0, g, act);
        rst = 1'b0;
        pending = '1;
        for (int j = 0; j < N; j++) begin
            step(pending, g, act);
            pending &= ~g;
        end
        checks++;
        if (si !== 32'd4 || ss !== 32'd3) begin
            errors++;
            $display("FAIL stats: got issued=%0d stalls=%0d, want 4 3", si, ss);
        end
        idle(L + 1);
    endtask
`endif

    initial begin
        for (int i = 0; i < N; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        test_reset();
        test_all();
        test_single();
        test_wrap();
        test_arith();
        test_reset_mid();
        test_back_to_back();
`ifdef MUL_SHARE_ARBITER_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
